switch_frame_loader: RTL and testbench

- Upstream input stage for the convolution layer. Builds a 6x6 binary input frame one row at a time from six slide switches and a load push-button.
- Debounces both buttons and tracks the row pointer.
- Publishes a complete, stable 36-bit frame with a valid/ready handshake.
- The convolution stage consumes frame_out as its data_in; with no backpressure, frame_ready is tied high.

---
 rtl/switch_frame_loader.sv | 109 ++++++++++
 tb/tb_switch_frame_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/switch_frame_loader.sv
// switch_frame_loader: assembles a ROWS x COLS binary frame one switch row per debounced load press
// and publishes it with a valid/ready handshake; a debounced clear press wipes everything.
module switch_frame_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ROWS            = 6,
  parameter int COLS            = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      sw_row,
  input  logic                 btn_load,
  input  logic                 btn_clear,
  input  logic                 frame_ready,
  output logic [ROWS*COLS-1:0] frame_out,
  output logic                 frame_valid,
  output logic [2:0]           row_ptr
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
  typedef enum logic {LOAD, FULL} state_t;
  state_t               state_q, state_d;
  logic [COLS-1:0]      sw_s1_q, sw_s2_q;
  logic [1:0]           btn_s1_q, btn_s2_q, stb_q, stb_d, prev_q, arm_q, arm_d, press;
  logic [CW-1:0]        cnt_q [2];
  logic [CW-1:0]        cnt_d [2];
  logic [ROWS*COLS-1:0] shadow_q, shadow_d, frame_q, frame_d;
  logic                 valid_q, valid_d;
  logic [2:0]           row_q, row_d;
  // bit 0 is load, bit 1 is clear
  assign press = stb_q & ~prev_q;
  // An unarmed debouncer first needs DEBOUNCE_CYCLES of a released button, so a
  // button held through reset can never produce a press.
  always_comb begin
    stb_d = stb_q;
    arm_d = arm_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (!arm_q[i]) begin
        if (!btn_s1_q[i] && !btn_s2_q[i]) begin
          if (cnt_q[i] == LAST) arm_d[i] = 1'b1;
          else cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (btn_s2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == LAST) stb_d[i] = btn_s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    row_d    = row_q;
    if (press[1]) begin
      state_d  = LOAD;
      shadow_d = '0;
      frame_d  = '0;
      valid_d  = 1'b0;
      row_d    = '0;
    end else if (state_q == LOAD && press[0]) begin
      shadow_d[COLS*row_q +: COLS] = sw_s2_q;
      row_d = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
      if (row_q == ROW_LAST) begin
        frame_d = shadow_d;
        valid_d = 1'b1;
        state_d = FULL;
      end
    end else if (state_q == FULL && valid_q && frame_ready) begin
      state_d = LOAD;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      stb_q    <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q  <= LOAD;
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      row_q    <= '0;
    end else begin
      sw_s1_q  <= sw_row;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= {btn_clear, btn_load};
      btn_s2_q <= btn_s1_q;
      stb_q    <= stb_d;
      prev_q   <= stb_q;
      arm_q    <= arm_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      row_q    <= row_d;
    end
  end
  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign row_ptr     = row_q;
endmodule

// File: tb/tb_switch_frame_loader.sv
// tb_switch_frame_loader: directed test of the frame loader with DEBOUNCE_CYCLES=4.
module tb_switch_frame_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  sw_row = '0;
  logic        btn_load = 1'b0;
  logic        btn_clear = 1'b0;
  logic        frame_ready = 1'b0;
  logic [35:0] frame_out;
  logic        frame_valid;
  logic [2:0]  row_ptr;
  int          errors = 0;
  int          checks = 0;

  switch_frame_loader #(.DEBOUNCE_CYCLES(4), .ROWS(6), .COLS(6)) dut (
    .clk(clk), .rst_n(rst_n), .sw_row(sw_row), .btn_load(btn_load), .btn_clear(btn_clear),
    .frame_ready(frame_ready), .frame_out(frame_out), .frame_valid(frame_valid), .row_ptr(row_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Held press: the row write lands on the 7th edge after the button rises (2 sync + D + 1).
  task automatic press(input logic [5:0] sw, input logic [2:0] r_before, input logic [2:0] r_after);
    sw_row = sw;
    btn_load = 1'b1;
    tick(6);
    check("row_before_write", 36'(row_ptr), 36'(r_before));
    tick(1);
    check("row_after_write", 36'(row_ptr), 36'(r_after));
  endtask

  task automatic release_load();
    btn_load = 1'b0;
    tick(8);
  endtask

  initial begin
    tick(2);
    check("reset_frame", frame_out, 36'h0);
    check("reset_valid", 36'(frame_valid), 36'h0);
    check("reset_row", 36'(row_ptr), 36'h0);
    rst_n = 1'b1;
    tick(10);

    // fill a frame with a walking one, no downstream acceptance
    press(6'h01, 3'd0, 3'd1); release_load();
    press(6'h02, 3'd1, 3'd2); release_load();
    press(6'h04, 3'd2, 3'd3); release_load();
    press(6'h08, 3'd3, 3'd4); release_load();
    press(6'h10, 3'd4, 3'd5); release_load();
    check("valid_before_last", 36'(frame_valid), 36'h0);
    press(6'h20, 3'd5, 3'd0);
    check("valid_on_last", 36'(frame_valid), 36'h1);
    check("frame_walk", frame_out, 36'h810204081);
    release_load();
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i % 10 == 0) check("frame_held", frame_out, 36'h810204081);
    end
    check("valid_held", 36'(frame_valid), 36'h1);

    // loads while full are ignored, then handshake
    press(6'h3F, 3'd0, 3'd0); release_load();
    press(6'h3F, 3'd0, 3'd0); release_load();
    check("frame_full_ignore", frame_out, 36'h810204081);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("valid_handshake", 36'(frame_valid), 36'h0);
    check("frame_after_hs", frame_out, 36'h810204081);
    press(6'h15, 3'd0, 3'd1); release_load();

    // clear alone
    btn_clear = 1'b1;
    tick(7);
    check("clear_row", 36'(row_ptr), 36'h0);
    check("clear_frame", frame_out, 36'h0);
    btn_clear = 1'b0;
    tick(8);

    // short glitches never reach the debounce threshold
    btn_load = 1'b1; tick(3);
    btn_load = 1'b0; tick(2);
    btn_load = 1'b1; tick(3);
    btn_load = 1'b0; tick(10);
    check("glitch_row", 36'(row_ptr), 36'h0);
    press(6'h2A, 3'd0, 3'd1);
    tick(3);
    release_load();
    check("long_hold_one_write", 36'(row_ptr), 36'h1);

    // clear beats a simultaneous load
    press(6'h11, 3'd1, 3'd2); release_load();
    press(6'h22, 3'd2, 3'd3); release_load();
    btn_load = 1'b1;
    btn_clear = 1'b1;
    tick(7);
    check("clr_load_row", 36'(row_ptr), 36'h0);
    check("clr_load_valid", 36'(frame_valid), 36'h0);
    check("clr_load_frame", frame_out, 36'h0);
    btn_load = 1'b0;
    btn_clear = 1'b0;
    tick(8);
    check("clr_load_no_write", 36'(row_ptr), 36'h0);

    // reset mid-debounce with load held
    press(6'h01, 3'd0, 3'd1); release_load();
    press(6'h03, 3'd1, 3'd2); release_load();
    press(6'h07, 3'd2, 3'd3); release_load();
    press(6'h0F, 3'd3, 3'd4); release_load();
    btn_load = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("async_rst_row", 36'(row_ptr), 36'h0);
    check("async_rst_valid", 36'(frame_valid), 36'h0);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("held_after_rst", 36'(row_ptr), 36'h0);
    release_load();
    press(6'h3F, 3'd0, 3'd1); release_load();

    // frame_ready tied high: one-cycle valid
    frame_ready = 1'b1;
    press(6'h3E, 3'd1, 3'd2); release_load();
    press(6'h3D, 3'd2, 3'd3); release_load();
    press(6'h3B, 3'd3, 3'd4); release_load();
    press(6'h37, 3'd4, 3'd5); release_load();
    press(6'h2F, 3'd5, 3'd0);
    check("auto_valid_high", 36'(frame_valid), 36'h1);
    check("auto_frame", frame_out, 36'hBF7EFDFBF);
    tick(1);
    check("auto_valid_drop", 36'(frame_valid), 36'h0);
    release_load();
    check("auto_valid_low", 36'(frame_valid), 36'h0);
    check("auto_frame_kept", frame_out, 36'hBF7EFDFBF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
